// File: rtl/six_tf.sv
// six_tf: 3-stage 6-tap (1,-5,20,20,-5,1) half-pel filter, rounded and clipped.
// Optional raw S2 sum output enabled by defining SIX_TF_RAW_OUT_EN.
module six_tf #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] half,
    output logic              out_valid
`ifdef SIX_TF_RAW_OUT_EN
    ,
    output logic signed [SUM_W-1:0] raw_sum
`endif
);

    localparam logic signed [SUM_W-1:0] RND  = SUM_W'(16);
    localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 << DATA_W) - 1);

    // S1: symmetric taps folded into pair sums
    logic [DATA_W:0] af_d, be_d, cd_d;
    logic [DATA_W:0] af_q, be_q, cd_q;
    logic            v1_q;

    assign af_d = {1'b0, a} + {1'b0, f};
    assign be_d = {1'b0, b} + {1'b0, e};
    assign cd_d = {1'b0, c} + {1'b0, d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            af_q <= '0;
            be_q <= '0;
            cd_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                af_q <= af_d;
                be_q <= be_d;
                cd_q <= cd_d;
            end
        end
    end

    // S2: weighted sum with shift-add multiplies
    logic signed [SUM_W-1:0] af_x, be_x, cd_x;
    logic signed [SUM_W-1:0] be5, cd20;
    logic signed [SUM_W-1:0] sum_d, sum_q;
    logic                    v2_q;

    assign af_x  = SUM_W'(af_q);
    assign be_x  = SUM_W'(be_q);
    assign cd_x  = SUM_W'(cd_q);
    assign be5   = (be_x <<< 2) + be_x;
    assign cd20  = (cd_x <<< 4) + (cd_x <<< 2);
    assign sum_d = af_x - be5 + cd20;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                sum_q <= sum_d;
            end
        end
    end

    // S3: round half up, arithmetic shift, clip to pixel range
    logic signed [SUM_W-1:0] rnd, shr;
    logic [DATA_W-1:0]       clip_d;
    logic [DATA_W-1:0]       half_q;
    logic                    ov_q;

    assign rnd = sum_q + RND;
    assign shr = rnd >>> 5;

    always_comb begin
        clip_d = shr[DATA_W-1:0];
        if (shr < 0) begin
            clip_d = '0;
        end else if (shr > MAXV) begin
            clip_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_q <= '0;
            ov_q   <= 1'b0;
        end else begin
            ov_q <= v2_q;
            if (v2_q) begin
                half_q <= clip_d;
            end
        end
    end

    assign half      = half_q;
    assign out_valid = ov_q;

`ifdef SIX_TF_RAW_OUT_EN
    logic signed [SUM_W-1:0] raw_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q <= '0;
        end else if (v2_q) begin
            raw_q <= sum_q;
        end
    end

    assign raw_sum = raw_q;
`else
`endif

endmodule

// File: tb/tb_six_tf.sv
// tb_six_tf: directed and random stimulus for six_tf against a formula-level
// reference model holding expected results with their due cycle.
module tb_six_tf;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0;
    logic [7:0] half;
    logic       out_valid;
`ifdef SIX_TF_RAW_OUT_EN
    logic signed [14:0] raw_sum;
`endif

    six_tf #(.DATA_W(8), .SUM_W(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .f        (f),
        .half     (half),
        .out_valid(out_valid)
`ifdef SIX_TF_RAW_OUT_EN
        ,
        .raw_sum  (raw_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
        int raw;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   last_val = 0;
    int   last_raw = 0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, want, cyc);
    endtask

    function automatic int model_raw(input int pa, pb, pc, pd, pe, pf);
        return pa - 5 * pb + 20 * pc + 20 * pd - 5 * pe + pf;
    endfunction

    function automatic int model_half(input int s);
        int r;
        r = (s + 16) >>> 5;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic check_out();
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            last_val = exp_q[0].val;
            last_raw = exp_q[0].raw;
            void'(exp_q.pop_front());
            chk("out_valid_hi", {31'b0, out_valid}, 1);
        end else begin
            chk("out_valid_lo", {31'b0, out_valid}, 0);
        end
        chk("half", {24'b0, half}, last_val);
`ifdef SIX_TF_RAW_OUT_EN
        chk("raw_sum", raw_sum, last_raw);
`endif
    endtask

    // called at a falling edge: check, drive the next cycle's inputs, advance
    task automatic step(input logic v, input int pa, pb, pc, pd, pe, pf);
        exp_t x;
        check_out();
        in_valid = v;
        a = 8'(pa); b = 8'(pb); c = 8'(pc);
        d = 8'(pd); e = 8'(pe); f = 8'(pf);
        if (v) begin
            x.due = cyc + 3;
            x.raw = model_raw(pa, pb, pc, pd, pe, pf);
            x.val = model_half(x.raw);
            exp_q.push_back(x);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7, 7, 7, 7, 7, 7);
    endtask

    function automatic int rpix();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 0;
        if (k == 1) return 255;
        return int'($urandom_range(0, 255));
    endfunction

    initial begin
        #1;
        chk("rst_half", {24'b0, half}, 0);
        chk("rst_ov", {31'b0, out_valid}, 0);
`ifdef SIX_TF_RAW_OUT_EN
        chk("rst_raw", raw_sum, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // single flat vector: exact 3-cycle latency
        step(1'b1, 100, 100, 100, 100, 100, 100);
        idle(4);

        // directed corner vectors back to back
        step(1'b1, 10, 20, 30, 40, 50, 60);
        step(1'b1, 0, 0, 255, 255, 0, 0);
        step(1'b1, 255, 255, 255, 255, 255, 255);
        step(1'b1, 0, 255, 0, 0, 255, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0);
        idle(4);

        // five distinct vectors streamed, then hold
        step(1'b1, 1, 2, 3, 4, 5, 6);
        step(1'b1, 200, 10, 90, 91, 12, 180);
        step(1'b1, 50, 60, 70, 80, 90, 100);
        step(1'b1, 255, 0, 128, 127, 0, 255);
        step(1'b1, 9, 200, 40, 45, 190, 3);
        idle(6);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 rpix(), rpix(), rpix(), rpix(), rpix(), rpix());
        end
        idle(4);

        // asynchronous reset with two samples in flight
        step(1'b1, 100, 100, 100, 100, 100, 100);
        step(1'b1, 0, 0, 255, 255, 0, 0);
        check_out();
        in_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_half", {24'b0, half}, 0);
        chk("arst_ov", {31'b0, out_valid}, 0);
`ifdef SIX_TF_RAW_OUT_EN
        chk("arst_raw", raw_sum, 0);
`endif
        exp_q.delete();
        last_val = 0;
        last_raw = 0;
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        idle(5);
        step(1'b1, 10, 20, 30, 40, 50, 60);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
